csnn_patch_streamer: RTL and testbench

Parametrised receptive-field extractor for the CSNN input stage. It holds one binary IMG_H×IMG_W image and walks a K×K window across it with stride STRIDE. Each window is emitted as a K*K-bit field on a valid/ready stream for the convolution/neuron stage. All fields of the frame are also packed into one code word for classification front-ends that consume a whole frame at once. It generalises the fixed 5×5 / 2×2 / stride-1 coder: geometry is parametrised, output is per-field with back-pressure, and a frame sequencer is added.

---
 rtl/csnn_patch_streamer.sv | 139 +++++++++++++
 tb/tb_csnn_patch_streamer.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csnn_patch_streamer.sv
// rtl/csnn_patch_streamer.sv - K x K receptive-field streamer over a binary image
module csnn_patch_streamer #(
    parameter int IMG_H  = 5,
    parameter int IMG_W  = 5,
    parameter int K      = 2,
    parameter int STRIDE = 1,
    localparam int OUT_H  = (IMG_H - K) / STRIDE + 1,
    localparam int OUT_W  = (IMG_W - K) / STRIDE + 1,
    localparam int NF     = OUT_H * OUT_W,
    localparam int KK     = K * K,
    localparam int NP     = IMG_H * IMG_W,
    localparam int CODE_W = NF * KK,
    localparam int RW     = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int CW     = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              img_load,
    input  logic [NP-1:0]     img_data,
    input  logic              start,
    output logic              busy,
    output logic              field_valid,
    input  logic              field_ready,
    output logic [KK-1:0]     field_data,
    output logic [RW-1:0]     field_row,
    output logic [CW-1:0]     field_col,
    output logic              field_last,
    output logic [CODE_W-1:0] code_out,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [NP-1:0]     img_q;
    logic [RW-1:0]     row_q;
    logic [CW-1:0]     col_q;
    logic [CODE_W-1:0] code_q;
    logic [NP-1:0]     pix_sh;
    logic              start_ok;
    logic              fire;
    logic              at_end;

    // A simultaneous load takes priority over start, so start only counts without a load
    assign start_ok = (state_q == S_IDLE) && start && !img_load;
    assign fire     = (state_q == S_RUN) && field_ready;
    assign at_end   = (row_q == RW'(OUT_H - 1)) && (col_q == CW'(OUT_W - 1));

    assign field_row  = row_q;
    assign field_col  = col_q;
    assign field_last = at_end && field_valid;
    assign code_out   = code_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        field_valid = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy        = 1'b1;
                field_valid = 1'b1;
                if (field_ready && at_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Image register: only writable between frames so a scan always sees one image
    always_ff @(posedge clk) begin
        if (rst) begin
            img_q <= '0;
        end else if (img_load && (state_q == S_IDLE)) begin
            img_q <= img_data;
        end
    end

    // Window counters and packed code word, advanced on each accepted field
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            col_q  <= '0;
            code_q <= '0;
        end else if (start_ok) begin
            row_q  <= '0;
            col_q  <= '0;
            code_q <= '0;
        end else if (fire) begin
            code_q <= (code_q << KK) | CODE_W'(field_data);
            if (at_end) begin
                // Park at the origin so the counters never index past the image
                row_q <= '0;
                col_q <= '0;
            end else if (col_q == CW'(OUT_W - 1)) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Window extraction: top-left pixel shifted in first so it lands at the MSB
    always_comb begin
        field_data = '0;
        pix_sh     = '0;
        for (int a = 0; a < K; a++) begin
            for (int b = 0; b < K; b++) begin
                pix_sh     = img_q >> (NP - 1 - ((int'(row_q) * STRIDE + a) * IMG_W
                                                 + int'(col_q) * STRIDE + b));
                field_data = (field_data << 1) | KK'(pix_sh[0]);
            end
        end
    end

endmodule

// File: tb/tb_csnn_patch_streamer.sv
// tb/tb_csnn_patch_streamer.sv - scoreboard bench for csnn_patch_streamer
module tb_csnn_patch_streamer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    localparam logic [24:0] IMG1 = 25'b11011_00100_00100_00100_00100;
    localparam logic [24:0] IMG2 = 25'h1A55A5A;
    localparam logic [24:0] IMG3 = 25'h0F0F0F3;

    typedef struct {
        logic [15:0] data;
        int          row;
        int          col;
        logic        last;
    } fld_t;

    // Instance A: default geometry 5x5, K=2, STRIDE=1
    logic        a_load = 1'b0, a_start = 1'b0, a_ready = 1'b0;
    logic [24:0] a_img = '0;
    logic        a_busy, a_valid, a_last, a_done;
    logic [3:0]  a_data;
    logic [1:0]  a_row, a_col;
    logic [63:0] a_code;
    csnn_patch_streamer u_a (
        .clk(clk), .rst(rst), .img_load(a_load), .img_data(a_img), .start(a_start),
        .busy(a_busy), .field_valid(a_valid), .field_ready(a_ready), .field_data(a_data),
        .field_row(a_row), .field_col(a_col), .field_last(a_last), .code_out(a_code), .done(a_done)
    );

    // Instance B: 6x6, K=3, STRIDE=3
    logic        b_load = 1'b0, b_start = 1'b0, b_ready = 1'b1;
    logic [35:0] b_img = '0;
    logic        b_busy, b_valid, b_last, b_done;
    logic [8:0]  b_data;
    logic [0:0]  b_row, b_col;
    logic [35:0] b_code;
    csnn_patch_streamer #(.IMG_H(6), .IMG_W(6), .K(3), .STRIDE(3)) u_b (
        .clk(clk), .rst(rst), .img_load(b_load), .img_data(b_img), .start(b_start),
        .busy(b_busy), .field_valid(b_valid), .field_ready(b_ready), .field_data(b_data),
        .field_row(b_row), .field_col(b_col), .field_last(b_last), .code_out(b_code), .done(b_done)
    );

    // Instance C: 5x5, K=2, STRIDE=2 (last row/column unused)
    logic        c_load = 1'b0, c_start = 1'b0, c_ready = 1'b1;
    logic [24:0] c_img = '0;
    logic        c_busy, c_valid, c_last, c_done;
    logic [3:0]  c_data;
    logic [0:0]  c_row, c_col;
    logic [15:0] c_code;
    csnn_patch_streamer #(.IMG_H(5), .IMG_W(5), .K(2), .STRIDE(2)) u_c (
        .clk(clk), .rst(rst), .img_load(c_load), .img_data(c_img), .start(c_start),
        .busy(c_busy), .field_valid(c_valid), .field_ready(c_ready), .field_data(c_data),
        .field_row(c_row), .field_col(c_col), .field_last(c_last), .code_out(c_code), .done(c_done)
    );

    // Instance D: 2x2, K=2 (single field per frame)
    logic        d_load = 1'b0, d_start = 1'b0, d_ready = 1'b1;
    logic [3:0]  d_img = '0;
    logic        d_busy, d_valid, d_last, d_done;
    logic [3:0]  d_data;
    logic [0:0]  d_row, d_col;
    logic [3:0]  d_code;
    csnn_patch_streamer #(.IMG_H(2), .IMG_W(2), .K(2), .STRIDE(1)) u_d (
        .clk(clk), .rst(rst), .img_load(d_load), .img_data(d_img), .start(d_start),
        .busy(d_busy), .field_valid(d_valid), .field_ready(d_ready), .field_data(d_data),
        .field_row(d_row), .field_col(d_col), .field_last(d_last), .code_out(d_code), .done(d_done)
    );

    fld_t        a_q[$];
    fld_t        b_q[$];
    logic [63:0] a_exp_code;
    logic        a_stalled = 1'b0;
    logic [3:0]  a_pd;
    logic [1:0]  a_pr, a_pc;

    function automatic logic [15:0] model_field(input logic [63:0] img, input int h, input int w,
                                                input int k, input int s, input int r, input int c);
        logic [63:0] t;
        logic [15:0] f;
        f = '0;
        for (int a = 0; a < k; a++) begin
            for (int b = 0; b < k; b++) begin
                t = img >> (h * w - 1 - ((r * s + a) * w + c * s + b));
                f = {f[14:0], t[0]};
            end
        end
        return f;
    endfunction

    task automatic push_a(input logic [24:0] img);
        fld_t e;
        a_exp_code = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                e.data = model_field({39'b0, img}, 5, 5, 2, 1, r, c);
                e.row  = r;
                e.col  = c;
                e.last = (r == 3) && (c == 3);
                a_q.push_back(e);
                a_exp_code = {a_exp_code[59:0], e.data[3:0]};
            end
        end
    endtask

    task automatic load_a(input logic [24:0] img);
        a_img = img;
        a_load = 1'b1;
        @(posedge clk); #1;
        a_load = 1'b0;
    endtask

    // Instance A output monitor: pops the scoreboard on every accepted field
    always @(negedge clk) begin
        if (!rst && a_valid) begin
            checks++;
            if (a_q.size() == 0) begin
                failures++;
                $display("FAIL a_extra_field got data=%h row=%0d col=%0d expected no field", a_data, a_row, a_col);
            end else if (a_data !== a_q[0].data[3:0] || int'(a_row) !== a_q[0].row ||
                         int'(a_col) !== a_q[0].col || a_last !== a_q[0].last) begin
                failures++;
                $display("FAIL a_field got data=%h row=%0d col=%0d last=%b expected data=%h row=%0d col=%0d last=%b",
                         a_data, a_row, a_col, a_last, a_q[0].data[3:0], a_q[0].row, a_q[0].col, a_q[0].last);
            end
            if (a_stalled) begin
                checks++;
                if ({a_data, a_row, a_col} !== {a_pd, a_pr, a_pc}) begin
                    failures++;
                    $display("FAIL a_stall_hold got %h/%0d/%0d expected %h/%0d/%0d", a_data, a_row, a_col, a_pd, a_pr, a_pc);
                end
            end
            a_stalled = !a_ready;
            a_pd = a_data;
            a_pr = a_row;
            a_pc = a_col;
            if (a_ready && a_q.size() > 0) void'(a_q.pop_front());
        end else begin
            a_stalled = 1'b0;
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_busy, a_valid, a_last, a_done, a_data, a_row, a_col} !== '0 || a_code !== '0) begin
            failures++;
            $display("FAIL reset_a got busy=%b valid=%b data=%h code=%h expected all zero", a_busy, a_valid, a_data, a_code);
        end
        checks++;
        if ({b_busy, b_valid, b_done, c_busy, c_valid, c_done, d_busy, d_valid, d_done} !== '0) begin
            failures++;
            $display("FAIL reset_bcd got b=%b%b c=%b%b d=%b%b expected 0", b_busy, b_valid, c_busy, c_valid, d_busy, d_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int n;
        load_a(IMG1);
        push_a(IMG1);
        a_ready = 1'b1;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        n = 1;
        checks++;
        if (a_busy !== 1'b1 || a_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_first_cycle got busy=%b valid=%b expected 1 1", a_busy, a_valid);
        end
        while (!a_done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 17 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_done_timing got cycle=%0d busy=%b expected cycle=17 busy=1", n, a_busy);
        end
        checks++;
        if (a_code !== 64'hC96C_05A0_05A0_05A0) begin
            failures++;
            $display("FAIL basic_code got %h expected c96c05a005a005a0", a_code);
        end
        checks++;
        if (a_q.size() !== 0) begin
            failures++;
            $display("FAIL basic_fields_left got %0d expected 0", a_q.size());
        end
        @(posedge clk); #1;
        checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_code !== 64'hC96C_05A0_05A0_05A0) begin
            failures++;
            $display("FAIL basic_after_done got busy=%b done=%b code=%h expected 0 0 held", a_busy, a_done, a_code);
        end
    endtask

    task automatic test_random_ready;
        int n;
        push_a(IMG1);
        a_ready = 1'($urandom_range(0, 1));
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        n = 0;
        while (!a_done && n < 400) begin
            a_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        a_ready = 1'b1;
        checks++;
        if (a_done !== 1'b1 || a_code !== 64'hC96C_05A0_05A0_05A0) begin
            failures++;
            $display("FAIL random_ready_code got done=%b code=%h expected 1 c96c05a005a005a0", a_done, a_code);
        end
        checks++;
        if (a_q.size() !== 0) begin
            failures++;
            $display("FAIL random_ready_fields_left got %0d expected 0", a_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore;
        int n;
        load_a(IMG2);
        push_a(IMG2);
        a_ready = 1'b1;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a_start = 1'b1;
        a_load = 1'b1;
        a_img = ~IMG2;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_load = 1'b0;
        n = 0;
        while (!a_done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (a_done !== 1'b1 || a_code !== a_exp_code) begin
            failures++;
            $display("FAIL ignore_run_code got done=%b code=%h expected 1 %h", a_done, a_code, a_exp_code);
        end
        @(posedge clk); #1;
        a_start = 1'b1;
        a_load = 1'b1;
        a_img = IMG3;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_load = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_busy !== 1'b0 || a_valid !== 1'b0) begin
            failures++;
            $display("FAIL ignore_load_wins got busy=%b valid=%b expected 0 0", a_busy, a_valid);
        end
        push_a(IMG3);
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        n = 0;
        while (!a_done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (a_done !== 1'b1 || a_code !== a_exp_code) begin
            failures++;
            $display("FAIL ignore_new_image_code got done=%b code=%h expected 1 %h", a_done, a_code, a_exp_code);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int n;
        push_a(IMG3);
        a_ready = 1'b1;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (a_valid !== 1'b1 || a_row !== 2'd1 || a_col !== 2'd1) begin
            failures++;
            $display("FAIL reset_mid_position got valid=%b row=%0d col=%0d expected 1 1 1", a_valid, a_row, a_col);
        end
        rst = 1'b1;
        a_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_busy !== 1'b0 || a_valid !== 1'b0 || a_done !== 1'b0 || a_code !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got busy=%b valid=%b done=%b code=%h expected 0 0 0 0",
                     a_busy, a_valid, a_done, a_code);
        end
        rst = 1'b0;
        a_q.delete();
        a_stalled = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_done got done=%b busy=%b expected 0 0", a_done, a_busy);
        end
        push_a(25'b0);
        a_ready = 1'b1;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        n = 0;
        while (!a_done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (a_done !== 1'b1 || a_code !== '0 || a_q.size() !== 0) begin
            failures++;
            $display("FAIL reset_mid_zero_frame got done=%b code=%h left=%0d expected 1 0 0", a_done, a_code, a_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stride_cover;
        int n;
        fld_t e;
        logic [35:0] img;
        logic [8:0] pat [4];
        pat[0] = 9'h155; pat[1] = 9'h0AA; pat[2] = 9'h0AA; pat[3] = 9'h155;
        img = '0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                img = (img << 1) | 36'(((r + c) % 2) == 0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            e.data = {7'b0, pat[i]};
            e.row = i / 2;
            e.col = i % 2;
            e.last = (i == 3);
            b_q.push_back(e);
        end
        b_img = img;
        b_load = 1'b1;
        @(posedge clk); #1;
        b_load = 1'b0;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        n = 0;
        while (!b_done && n < 50) begin
            if (b_valid) begin
                checks++;
                if (b_q.size() == 0) begin
                    failures++;
                    $display("FAIL stride_extra_field got data=%h expected none", b_data);
                end else begin
                    if (b_data !== b_q[0].data[8:0] || int'(b_row) !== b_q[0].row ||
                        int'(b_col) !== b_q[0].col || b_last !== b_q[0].last) begin
                        failures++;
                        $display("FAIL stride_field got data=%h row=%0d col=%0d last=%b expected data=%h row=%0d col=%0d last=%b",
                                 b_data, b_row, b_col, b_last, b_q[0].data[8:0], b_q[0].row, b_q[0].col, b_q[0].last);
                    end
                    void'(b_q.pop_front());
                end
            end
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (b_done !== 1'b1 || b_code !== {9'h155, 9'h0AA, 9'h0AA, 9'h155} || b_q.size() !== 0) begin
            failures++;
            $display("FAIL stride_code got done=%b code=%h left=%0d expected 1 %h 0",
                     b_done, b_code, b_q.size(), {9'h155, 9'h0AA, 9'h0AA, 9'h155});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_leftover;
        int n;
        logic [15:0] exp_code;
        logic [15:0] first_code;
        logic [15:0] f;
        c_img = 25'h0D39A71;
        first_code = '0;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) c_img[0] = ~c_img[0];
            exp_code = '0;
            for (int i = 0; i < 4; i++) begin
                f = model_field({39'b0, c_img}, 5, 5, 2, 2, i / 2, i % 2);
                exp_code = {exp_code[11:0], f[3:0]};
            end
            c_load = 1'b1;
            @(posedge clk); #1;
            c_load = 1'b0;
            c_start = 1'b1;
            @(posedge clk); #1;
            c_start = 1'b0;
            n = 0;
            while (!c_done && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (c_done !== 1'b1 || c_code !== exp_code) begin
                failures++;
                $display("FAIL leftover_code pass=%0d got done=%b code=%h expected 1 %h", pass, c_done, c_code, exp_code);
            end
            if (pass == 0) begin
                first_code = c_code;
            end else begin
                checks++;
                if (c_code !== first_code) begin
                    failures++;
                    $display("FAIL leftover_unused_pixel got %h expected %h", c_code, first_code);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single_field;
        d_img = 4'b1011;
        d_load = 1'b1;
        @(posedge clk); #1;
        d_load = 1'b0;
        d_start = 1'b1;
        @(posedge clk); #1;
        d_start = 1'b0;
        checks++;
        if (d_valid !== 1'b1 || d_last !== 1'b1 || d_data !== 4'hB) begin
            failures++;
            $display("FAIL single_field got valid=%b last=%b data=%h expected 1 1 b", d_valid, d_last, d_data);
        end
        @(posedge clk); #1;
        checks++;
        if (d_done !== 1'b1 || d_code !== 4'hB || d_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_done got done=%b code=%h valid=%b expected 1 b 0", d_done, d_code, d_valid);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_random_ready();
        test_ignore();
        test_reset_mid();
        test_stride_cover();
        test_leftover();
        test_single_field();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
